// File: rtl/cnn_layer_accel_weight_loader_if.sv
// Job descriptor, upstream weight stream and weight-table configuration
// signals of the weight loader, bundled as one bus.
// master: upstream job/weight source side; slave: the loader itself.
interface cnn_layer_accel_weight_loader_if #(
  parameter int unsigned C_WEIGHT_WIDTH = 16
);
  // upstream job descriptor and weight stream
  logic                      job_start;
  logic [15:0]               job_num_kernels;
  logic                      wht_in_valid;
  logic [C_WEIGHT_WIDTH-1:0] wht_in_data;
  logic                      wht_in_ready;

  // weight table configuration protocol and status
  logic                      job_accept;
  logic                      kernel_config_valid;
  logic [15:0]               num_kernels;
  logic                      config_mode;
  logic                      wht_config_wren;
  logic [C_WEIGHT_WIDTH-1:0] wht_config_data;
  logic                      config_done;
  logic                      busy;
  logic                      cfg_error;

  modport master (
    output job_start, job_num_kernels, wht_in_valid, wht_in_data,
    input  wht_in_ready, job_accept, kernel_config_valid, num_kernels,
           config_mode, wht_config_wren, wht_config_data, config_done,
           busy, cfg_error
  );

  modport slave (
    input  job_start, job_num_kernels, wht_in_valid, wht_in_data,
    output wht_in_ready, job_accept, kernel_config_valid, num_kernels,
           config_mode, wht_config_wren, wht_config_data, config_done,
           busy, cfg_error
  );
endinterface

// File: rtl/cnn_layer_accel_weight_loader.sv
// Weight loader: buffers one 3x3 kernel of upstream weights at a time and
// replays it to the weight table as an unbroken burst, framed by the
// table's job-accept / kernel-config / config-mode handshake.
module cnn_layer_accel_weight_loader #(
  parameter int unsigned C_KERNEL_WORDS = 9,
  parameter int unsigned C_MAX_KERNELS  = 64,
  parameter int unsigned C_WEIGHT_WIDTH = 16
) (
  input logic                              clk,
  input logic                              rst,
  cnn_layer_accel_weight_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_FILL,
    S_BURST,
    S_DONE
  } state_e;

  localparam logic [3:0]  LAST_WORD = 4'(C_KERNEL_WORDS - 1);
  localparam logic [15:0] MAX_K     = 16'(C_MAX_KERNELS);

  state_e                    state_q, state_d;
  logic [3:0]                word_cnt_q, word_cnt_d;
  logic [5:0]                kernel_idx_q, kernel_idx_d;
  logic [C_WEIGHT_WIDTH-1:0] wbuf_q [C_KERNEL_WORDS];
  logic [C_WEIGHT_WIDTH-1:0] wbuf_d [C_KERNEL_WORDS];

  logic                      ready_q, ready_d;
  logic                      job_accept_q, job_accept_d;
  logic                      kcv_q, kcv_d;
  logic [15:0]               num_kernels_q, num_kernels_d;
  logic                      mode_q, mode_d;
  logic                      wren_q, wren_d;
  logic [C_WEIGHT_WIDTH-1:0] data_q, data_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;

  logic                      hs;

  assign hs = bus.wht_in_valid & ready_q;

  // Next-state, buffer/counter update and next registered outputs.
  // Outputs are derived from state_d so every output register lines up
  // with the state register in the same cycle.
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    kernel_idx_d  = kernel_idx_q;
    num_kernels_d = num_kernels_q;
    data_d        = data_q;
    err_d         = 1'b0;
    wbuf_d        = wbuf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.job_start) begin
          if (bus.job_num_kernels < MAX_K) begin
            num_kernels_d = bus.job_num_kernels;
            state_d       = S_ACCEPT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_ACCEPT: begin
        word_cnt_d   = '0;
        kernel_idx_d = '0;
        state_d      = S_FILL;
      end

      S_FILL: begin
        if (hs) begin
          wbuf_d[word_cnt_q] = bus.wht_in_data;
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            state_d    = S_BURST;
            // first burst word is staged now so the write strobe and its
            // data appear together on the cycle after the last handshake
            data_d     = wbuf_d[0];
          end else begin
            word_cnt_d = word_cnt_q + 4'd1;
          end
        end
      end

      S_BURST: begin
        if (word_cnt_q == LAST_WORD) begin
          word_cnt_d = '0;
          if (kernel_idx_q == num_kernels_q[5:0]) begin
            state_d = S_DONE;
          end else begin
            kernel_idx_d = kernel_idx_q + 6'd1;
            state_d      = S_FILL;
          end
        end else begin
          word_cnt_d = word_cnt_q + 4'd1;
          data_d     = wbuf_q[word_cnt_d];
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d      = (state_d == S_FILL);
    job_accept_d = (state_d == S_ACCEPT);
    kcv_d        = (state_d == S_ACCEPT);
    mode_d       = (state_d == S_ACCEPT) || (state_d == S_FILL) ||
                   (state_d == S_BURST);
    wren_d       = (state_d == S_BURST);
    done_d       = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  // State, counters, kernel buffer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      word_cnt_q    <= '0;
      kernel_idx_q  <= '0;
      for (int unsigned i = 0; i < C_KERNEL_WORDS; i++) begin
        wbuf_q[i] <= '0;
      end
      ready_q       <= 1'b0;
      job_accept_q  <= 1'b0;
      kcv_q         <= 1'b0;
      num_kernels_q <= '0;
      mode_q        <= 1'b0;
      wren_q        <= 1'b0;
      data_q        <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      kernel_idx_q  <= kernel_idx_d;
      wbuf_q        <= wbuf_d;
      ready_q       <= ready_d;
      job_accept_q  <= job_accept_d;
      kcv_q         <= kcv_d;
      num_kernels_q <= num_kernels_d;
      mode_q        <= mode_d;
      wren_q        <= wren_d;
      data_q        <= data_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign bus.wht_in_ready        = ready_q;
  assign bus.job_accept          = job_accept_q;
  assign bus.kernel_config_valid = kcv_q;
  assign bus.num_kernels         = num_kernels_q;
  assign bus.config_mode         = mode_q;
  assign bus.wht_config_wren     = wren_q;
  assign bus.wht_config_data     = data_q;
  assign bus.config_done         = done_q;
  assign bus.busy                = busy_q;
  assign bus.cfg_error           = err_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_loader.sv
// Scoreboard bench for the weight loader: the driver pushes every accepted
// upstream word into an expected-write queue; an independent monitor pops
// it on each table write and checks burst framing.
module tb_cnn_layer_accel_weight_loader;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cnn_layer_accel_weight_loader_if #(.C_WEIGHT_WIDTH(W)) bus ();

  cnn_layer_accel_weight_loader #(
    .C_KERNEL_WORDS(9),
    .C_MAX_KERNELS (64),
    .C_WEIGHT_WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  int cyc = 0;
  int writes = 0, bursts = 0, accepts = 0, dones = 0, run = 0;
  int done_cyc = 0;
  bit prev_wren = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: table-side writes against the scoreboard, burst length, done framing.
  always @(negedge clk) begin
    if (!rst) begin
      run       = 0;
      prev_wren = 1'b0;
    end else begin
      if (bus.job_accept) accepts++;
      if (bus.wht_config_wren) begin
        writes++;
        run++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: write of 0x%0h with empty scoreboard (t=%0t)",
                   bus.wht_config_data, $time);
        end else begin
          chk("wr_data", bus.wht_config_data, exp_q.pop_front());
        end
        chk("wr_config_mode", bus.config_mode, 1);
      end else if (run > 0) begin
        bursts++;
        chk("burst_len", run, 9);
        run = 0;
      end
      if (bus.config_done) begin
        chk("done_after_last_write", prev_wren, 1);
        chk("done_config_mode", bus.config_mode, 0);
        chk("done_scoreboard_empty", exp_q.size(), 0);
        done_cyc = cyc;
        dones++;
      end
      prev_wren = bus.wht_config_wren;
    end
  end

  // Pulse job_start for one cycle; returns 1ns after the edge that sampled it.
  task automatic start_job(input logic [15:0] n, output int t0);
    @(posedge clk);
    #1;
    bus.job_start       = 1'b1;
    bus.job_num_kernels = n;
    t0 = cyc;
    @(posedge clk);
    #1;
    bus.job_start = 1'b0;
  endtask

  // Offer one word after optional idle cycles; returns 1ns after its handshake.
  task automatic send_word(input logic [W-1:0] d, input int gaps, input bit inject);
    bit ok;
    if (gaps > 0) begin
      bus.wht_in_valid = 1'b0;
      repeat (gaps) @(posedge clk);
      #1;
    end
    bus.wht_in_valid = 1'b1;
    bus.wht_in_data  = d;
    if (inject) begin
      bus.job_start       = 1'b1;
      bus.job_num_kernels = 16'd5;
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.wht_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    if (ok) exp_q.push_back(d);
    #1;
    bus.wht_in_valid = 1'b0;
    bus.job_start    = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: wht_in_ready not seen within 200 cycles");
    end
  endtask

  // Full job: n+1 kernels; fixed data 1,2,3,... or random words.
  task automatic run_job(input logic [15:0] n, input int gapmax, input bit fixed,
                         input bit inj_fill, input bit inj_burst);
    int t0, acc0, b0, w0, d0, nk;
    logic [W-1:0] d;
    bit seen;
    nk   = int'(n) + 1;
    acc0 = accepts;
    b0   = bursts;
    w0   = writes;
    d0   = dones;
    start_job(n, t0);
    chk("accept_pulse", bus.job_accept, 1);
    chk("kernel_config_valid", bus.kernel_config_valid, 1);
    chk("accept_config_mode", bus.config_mode, 1);
    chk("accept_num_kernels", bus.num_kernels, n);
    chk("accept_busy", bus.busy, 1);
    @(posedge clk);
    #1;
    chk("ready_at_T2", bus.wht_in_ready, 1);
    for (int k = 0; k < nk; k++) begin
      for (int w = 0; w < 9; w++) begin
        int g;
        d = fixed ? W'(k * 9 + w + 1) : W'($urandom);
        g = 0;
        if (gapmax > 0 && $urandom_range(0, 2) == 0) g = $urandom_range(1, gapmax);
        send_word(d, g, inj_fill && k == 0 && w == 3);
      end
      chk("burst_starts_after_9th", bus.wht_config_wren, 1);
      if (inj_burst && k == 0) begin
        bus.job_start       = 1'b1;
        bus.job_num_kernels = 16'd7;
        @(posedge clk);
        #1;
        bus.job_start = 1'b0;
        chk("burst_inject_num_kernels", bus.num_kernels, n);
        chk("burst_inject_no_accept", bus.job_accept, 0);
      end
      if (inj_fill && k == 0) chk("fill_inject_num_kernels", bus.num_kernels, n);
    end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (dones != d0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: config_done not seen within 100 cycles");
    end else begin
      if (gapmax == 0) chk("job_length", done_cyc - t0, 2 + 18 * nk);
      @(negedge clk);
      chk("idle_busy", bus.busy, 0);
      chk("idle_config_mode", bus.config_mode, 0);
      chk("num_kernels_held", bus.num_kernels, n);
      chk("job_accept_count", accepts - acc0, 1);
      chk("job_burst_count", bursts - b0, nk);
      chk("job_write_count", writes - w0, 9 * nk);
    end
  endtask

  initial begin
    int t0;
    logic [15:0] held;
    bus.job_start       = 1'b0;
    bus.job_num_kernels = '0;
    bus.wht_in_valid    = 1'b0;
    bus.wht_in_data     = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {bus.job_accept, bus.kernel_config_valid, bus.num_kernels, bus.config_mode,
         bus.wht_config_wren, bus.wht_config_data, bus.config_done, bus.busy,
         bus.cfg_error, bus.wht_in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // single kernel, words 1..9, continuous valid
    run_job(16'd0, 0, 1'b1, 1'b0, 1'b0);

    // three kernels with random upstream gaps
    run_job(16'd2, 3, 1'b0, 1'b0, 1'b0);

    // out-of-range kernel counts are rejected
    held = bus.num_kernels;
    start_job(16'd64, t0);
    chk("reject64_cfg_error", bus.cfg_error, 1);
    chk("reject64_busy", bus.busy, 0);
    chk("reject64_no_accept", bus.job_accept, 0);
    chk("reject64_num_kernels", bus.num_kernels, held);
    @(posedge clk);
    #1;
    chk("reject64_error_one_cycle", bus.cfg_error, 0);
    chk("reject64_still_idle", bus.busy, 0);
    start_job(16'hFFFF, t0);
    chk("rejectFFFF_cfg_error", bus.cfg_error, 1);
    chk("rejectFFFF_busy", bus.busy, 0);

    // maximum job: 64 kernels
    run_job(16'd63, 0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("no_write_after_max_job", bus.wht_config_wren, 0);

    // job_start during FILL and BURST is ignored
    run_job(16'd1, 1, 1'b0, 1'b1, 1'b1);

    // reset during the 5th burst cycle discards the job
    start_job(16'd0, t0);
    @(posedge clk);
    #1;
    for (int w = 0; w < 9; w++) send_word(W'($urandom), 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_in_burst", bus.wht_config_wren, 1);
    rst = 1'b0;
    #1;
    chk("mid_reset_outputs",
        {bus.job_accept, bus.kernel_config_valid, bus.num_kernels, bus.config_mode,
         bus.wht_config_wren, bus.wht_config_data, bus.config_done, bus.busy,
         bus.cfg_error, bus.wht_in_ready}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    chk("mid_reset_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_job(16'd0, 2, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end
endmodule
